// File: rtl/pipe_issue_ctrl.sv
// Issue controller between ID and EX: register scoreboard for RAW/WAW stalls
// plus the run / single-step / halt sequencer.
module pipe_issue_ctrl #(
  parameter int unsigned NREG  = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             id_valid,
  input  logic [15:0]      id_instr,
  input  logic             wb_valid,
  input  logic [3:0]       wb_rd,
  output logic             issue,
  output logic             stall,
  output logic             bubble,
  output logic             halted,
  output logic [NREG-1:0]  busy_mask,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RUN    = 3'd1;
  localparam logic [2:0] STEP   = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] HALTED = 3'd4;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_LOAD = 4'b0010;
  localparam logic [3:0] OP_HALT = 4'b1111;

  logic [2:0]       state_q, state_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] opcode, rd, rs1, rs2;
  logic       is_alu, is_writer, is_halt;
  logic       hazard, can_go, halt_consume;

  assign opcode = id_instr[15:12];
  assign rd     = id_instr[11:8];
  assign rs1    = id_instr[7:4];
  assign rs2    = id_instr[3:0];

  assign is_alu    = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign is_writer = is_alu || (opcode == OP_LOAD);
  assign is_halt   = (opcode == OP_HALT);

  // Only the registered scoreboard is consulted; a same-cycle WB clear is not bypassed.
  assign hazard = id_valid & ((is_writer & busy_q[rd]) |
                              (is_alu & (busy_q[rs1] | busy_q[rs2])));

  assign can_go       = (state_q == RUN) || (state_q == STEP);
  assign halt_consume = can_go & id_valid & is_halt;

  assign issue       = can_go & id_valid & ~hazard & ~is_halt;
  assign stall       = ~can_go | (id_valid & hazard);
  assign bubble      = ~issue;
  assign halted      = (state_q == HALTED);
  assign busy_mask   = busy_q;
  assign stall_count = cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALTED: begin
        if (step)     state_d = STEP;
        else if (run) state_d = RUN;
      end
      RUN: begin
        if (halt_req || halt_consume) state_d = DRAIN;
      end
      STEP: begin
        if (issue)                         state_d = HALTED;
        else if (halt_consume || halt_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (busy_q == '0) state_d = HALTED;
      end
      default: state_d = IDLE;
    endcase
  end

  // Set is applied after clear so an issuing writer wins over a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (issue && is_writer) busy_d[rd] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (can_go && hazard && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: small fetch/EX/WB environment, queue of expected
// issued instructions, and per-cycle traces checked against hand-derived timing.
module tb_pipe_issue_ctrl;

  logic        clk, reset, run, step, halt_req;
  logic        id_valid, wb_valid;
  logic [15:0] id_instr;
  logic [3:0]  wb_rd;
  logic        issue, stall, bubble, halted;
  logic [15:0] busy_mask, stall_count;

  pipe_issue_ctrl #(.NREG(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .id_valid(id_valid), .id_instr(id_instr), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue(issue), .stall(stall), .bubble(bubble), .halted(halted),
    .busy_mask(busy_mask), .stall_count(stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [15:0] prog[$];
  logic [15:0] exp_q[$];
  logic        tr_is[$], tr_st[$], tr_bu[$], tr_ha[$];
  logic [15:0] tr_bm[$];

  logic       ex_v, wb_v;
  logic [3:0] ex_r, wb_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic writes(input logic [15:0] ins);
    return (ins[15:12] == 4'b0000) || (ins[15:12] == 4'b0001) || (ins[15:12] == 4'b0010);
  endfunction

  task automatic clear_trace();
    tr_is.delete(); tr_st.delete(); tr_bu.delete(); tr_ha.delete(); tr_bm.delete();
  endtask

  // One core cycle; entered just after a rising edge, returns just after the next one.
  task automatic run_cycle();
    logic       nxt_v, adv;
    logic [3:0] nxt_r;
    id_valid = (prog.size() > 0);
    id_instr = id_valid ? prog[0] : 16'h0000;
    wb_valid = wb_v;
    wb_rd    = wb_r;
    @(negedge clk);
    tr_is.push_back(issue); tr_st.push_back(stall); tr_bu.push_back(bubble);
    tr_ha.push_back(halted); tr_bm.push_back(busy_mask);
    if (issue) begin
      if (exp_q.size() == 0) check("spurious_issue", issue, 0);
      else check("issued_instr", id_instr, exp_q.pop_front());
    end
    nxt_v = issue & writes(id_instr);
    nxt_r = id_instr[11:8];
    adv   = id_valid & ~stall;
    @(posedge clk);
    #1;
    wb_v = ex_v; wb_r = ex_r;
    ex_v = nxt_v; ex_r = nxt_r;
    if (adv) void'(prog.pop_front());
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic load(input logic [15:0] ins, input logic expect_issue);
    prog.push_back(ins);
    if (expect_issue) exp_q.push_back(ins);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
    id_valid = 1'b0; id_instr = '0; wb_valid = 1'b0; wb_rd = '0;
    ex_v = 1'b0; wb_v = 1'b0; ex_r = '0; wb_r = '0;
    #2;
    check("rst_issue", issue, 0);
    check("rst_stall", stall, 1);
    check("rst_bubble", bubble, 1);
    check("rst_halted", halted, 0);
    check("rst_busy", busy_mask, 16'h0000);
    check("rst_count", stall_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // IDLE -> RUN, then independent ADD/SUB
    run = 1'b1;
    run_cycle();
    run = 1'b0;
    clear_trace();
    load(16'h0123, 1); load(16'h1432, 1);
    cycles(5);
    check("indep_issue0", tr_is[0], 1);
    check("indep_issue1", tr_is[1], 1);
    check("indep_busy1", tr_bm[1], 16'h0002);
    check("indep_busy2", tr_bm[2], 16'h0012);
    check("indep_count", stall_count, 0);
    check("indep_drained", exp_q.size(), 0);

    // RAW: SUB R4 = R1 - R2 after ADD R1
    clear_trace();
    load(16'h0123, 1); load(16'h1412, 1);
    cycles(6);
    check("raw_issue0", tr_is[0], 1);
    check("raw_stall1", {tr_st[1], tr_bu[1], tr_is[1]}, 3'b110);
    check("raw_stall2", {tr_st[2], tr_bu[2], tr_is[2]}, 3'b110);
    check("raw_issue3", tr_is[3], 1);
    check("raw_count", stall_count, 2);

    // WAW: ADD R5 after LOAD R5
    clear_trace();
    load(16'h2507, 1); load(16'h0523, 1);
    cycles(6);
    check("waw_busy1", tr_bm[1], 16'h0020);
    check("waw_stall2", {tr_st[2], tr_is[2]}, 2'b10);
    check("waw_issue3", tr_is[3], 1);
    check("waw_count", stall_count, 4);

    // HALT opcode after three writers, then drain
    clear_trace();
    load(16'h0123, 1); load(16'h2600, 1); load(16'h1723, 1);
    load(16'hF000, 0); load(16'h0899, 0);
    cycles(8);
    check("halt_three_issued", {tr_is[0], tr_is[1], tr_is[2]}, 3'b111);
    check("halt_consumed", {tr_is[3], tr_st[3], tr_bu[3]}, 3'b001);
    check("drain_stall", {tr_is[4], tr_st[4], tr_ha[4]}, 3'b010);
    check("drain_busy4", tr_bm[4], 16'h0080);
    check("drain_busy5", tr_bm[5], 16'h0000);
    check("drain_halted5", tr_ha[5], 0);
    check("drain_halted6", tr_ha[6], 1);
    check("drain_no_issue", {tr_is[4], tr_is[5], tr_is[6], tr_is[7]}, 4'b0000);

    // Single step from HALTED
    clear_trace();
    exp_q.push_back(16'h0899);
    load(16'h0A11, 0);
    step = 1'b1;
    run_cycle();
    step = 1'b0;
    cycles(5);
    check("step_wait", tr_is[0], 0);
    check("step_issue", tr_is[1], 1);
    check("step_issue_total",
          32'(tr_is[0]) + 32'(tr_is[1]) + 32'(tr_is[2]) + 32'(tr_is[3]) + 32'(tr_is[4]) +
          32'(tr_is[5]), 1);
    check("step_halted", tr_ha[2], 1);
    check("step_busy", tr_bm[2], 16'h0100);
    check("step_prog_left", prog.size(), 1);

    // Reset while draining with R4/R5 in flight
    prog.delete();
    run = 1'b1;
    run_cycle();
    run = 1'b0;
    load(16'h0423, 1); load(16'h0523, 1);
    run_cycle();
    halt_req = 1'b1;
    run_cycle();
    halt_req = 1'b0;
    id_valid = 1'b0; wb_valid = wb_v; wb_rd = wb_r;
    @(negedge clk);
    check("pre_rst_busy", busy_mask, 16'h0030);
    check("pre_rst_stall", {stall, halted, issue}, 3'b100);
    #1 reset = 1'b1;
    #1;
    check("async_rst_busy", busy_mask, 16'h0000);
    check("async_rst_outs", {issue, stall, bubble, halted}, 4'b0110);
    check("async_rst_count", stall_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ex_v = 1'b0; wb_v = 1'b0;
    exp_q.delete(); prog.delete();

    // Scoreboard must be clean: a writer to R4 issues at once
    clear_trace();
    run = 1'b1;
    run_cycle();
    run = 1'b0;
    load(16'h0423, 1);
    cycles(2);
    check("post_rst_idle", tr_st[0], 1);
    check("post_rst_issue", tr_is[1], 1);
    check("post_rst_all_issued", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_issue_ctrl.md
# pipe_issue_ctrl

Issue controller for the 4-stage 16-bit pipelined processor (IF → ID → EX → WB). It sits between the ID and EX stages. It decides each cycle whether the instruction held in IF_ID may advance into ID_EX, using a 16-entry register scoreboard to stall on RAW/WAW hazards against in-flight writes. It also sequences run, single-step and halt for the core.

## Interface
Parameters:
- NREG, 16, register-file entries; scoreboard width (fixed by 4-bit register fields)
- CNT_W, 16, width of stall cycle counter

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- run  in  1  level; start/continue free-running issue
- step  in  1  level; issue exactly one instruction, then halt
- halt_req  in  1  level; stop issuing and drain the pipeline
- id_valid  in  1  IF_ID holds a real instruction
- id_instr  in  16  IF_ID contents: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2
- wb_valid  in  1  WB stage is writing the register file this cycle
- wb_rd  in  4  destination register of that write
- issue  out  1  load id_instr into ID_EX this edge
- stall  out  1  hold PC and IF_ID this edge
- bubble  out  1  load NOP (opcode 4'b1110) into ID_EX this edge
- halted  out  1  state == HALTED
- busy_mask  out  16  registered scoreboard; bit r = write to Rr in flight
- stall_count  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Opcode decode:
  - 0000 ADD and 0001 SUB: read rs1 and rs2; write rd.
  - 0010 LOAD: write rd, no register read (address is the immediate in [3:0]).
  - 1111 HALT: no read, no write.
  - All other opcodes: NOP.
- hazard = id_valid & (busy[rd] for writers | busy[rs1] | busy[rs2] for ADD/SUB).
- The hazard check uses the registered busy_mask only. A scoreboard clear does not take effect until the following cycle; this is a deliberately conservative choice.
- Scoreboard update each edge:
  - If wb_valid, clear bit wb_rd.
  - If issue of a writer, set bit rd.
  - When both hit the same bit, set wins.
- FSM states: IDLE (reset), RUN, STEP, DRAIN, HALTED.
  - IDLE/HALTED: step → STEP (step has priority over run); otherwise run → RUN.
  - RUN: halt_req → DRAIN. A HALT opcode at ID (id_valid) is consumed without issuing → DRAIN.
  - STEP: on the first cycle with issue=1 → HALTED. A HALT opcode → DRAIN. halt_req → DRAIN.
  - DRAIN: busy_mask == 0 → HALTED.
- Combinational outputs:
  - can_go = state ∈ {RUN, STEP}.
  - issue = can_go & id_valid & ~hazard & opcode≠HALT.
  - stall = ~can_go | (id_valid & hazard).
  - bubble = ~issue.
  - In IDLE, DRAIN and HALTED: issue=0, stall=1, bubble=1.
  - When id_valid=0 in RUN: stall=0, bubble=1, so fetch keeps advancing.
  - A consumed HALT opcode: issue=0, stall=0 (IF_ID is overwritten), bubble=1.
- stall_count increments on each cycle with can_go & id_valid & hazard, and saturates at all-ones.

## Timing
- Reset values: state=IDLE, busy_mask=0, stall_count=0, halted=0, issue=0, stall=1, bubble=1.
- reset asserted mid-operation clears the scoreboard and FSM asynchronously. Outputs take their reset values within the same cycle, with no drain.
- issue/stall/bubble are purely combinational from current state and inputs; there is no added latency.
- The scoreboard bit is set on the same edge that loads ID_EX. The WB write for that instruction arrives 2 edges later; the bit is cleared on that edge.
- A dependent instruction therefore stalls for 2 cycles after its producer issues and issues on the 3rd cycle.
- Back-to-back independent instructions issue every cycle.
- run/step/halt_req are sampled only at edges. Holding step high while in HALTED re-enters STEP on each edge, so a new step requires a new high level after halted is seen.

## Test plan
- Reset, then run=1 with ADD R1=R2+R3 followed by SUB R4=R3-R2 (independent) → issue high 2 consecutive cycles; busy_mask=0x0002 then 0x0012; stall_count stays 0.
- ADD R1=R2+R3 followed by SUB R4=R1-R2 → SUB stalled 2 cycles (stall=1, bubble=1), issues on 3rd; stall_count=2.
- LOAD R5 followed by ADD R5=R2+R3 (WAW) → ADD stalled until wb_valid/wb_rd=5 clears bit 5.
- HALT opcode after 3 writers in RUN → no further issue; DRAIN until busy_mask=0; halted=1 exactly one cycle after the last WB clear.
- From HALTED, pulse step for one cycle → exactly one issue, then halted=1 again with busy_mask showing only that rd.
- Assert reset while in DRAIN with busy_mask=0x0030 → busy_mask=0, state IDLE, stall=1 immediately, before the next edge.
